// File: rtl/lottery_arbiter.sv
// lottery_arbiter: four-master bus arbiter. Among the masters that request, the one
// holding the largest ticket wins; ties go to the lowest index. An owner is forced to
// re-arbitrate after MAX_HOLD hready cycles. A locked owner keeps the bus until its
// hlock drops.
// Optional feature, macro LOTTERY_STARVE_GUARD_EN: each master gets a saturating
// loss counter. A requester whose counter has reached STARVE_LIMIT wins regardless
// of its ticket.
//
// state   | meaning
// IDLE    | nobody owns the bus; parked on DEFAULT_MASTER, arbitrate every edge
// OWNED   | winner owns the bus, hold counter running
// LOCKED  | winner is doing a locked transfer, no arbitration, hold counter frozen
module lottery_arbiter #(
  parameter int MAX_HOLD       = 8,
  parameter int STARVE_LIMIT   = 4,
  parameter int DEFAULT_MASTER = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] t0,
  input  logic [3:0] t1,
  input  logic [3:0] t2,
  input  logic [3:0] t3,
  input  logic [3:0] hbusreq,
  input  logic [3:0] hlock,
  input  logic       hready,
  output logic [3:0] hgrant,
  output logic [1:0] hmaster,
  output logic       hmastlock
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_OWNED  = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  localparam logic [1:0] DEF_IDX   = 2'(DEFAULT_MASTER);
  localparam logic [3:0] DEF_GRANT = 4'b0001 << DEFAULT_MASTER;
  localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

  // Reject parameter values the counters cannot represent.
  if (MAX_HOLD < 2 || MAX_HOLD > 15 || STARVE_LIMIT < 1 || STARVE_LIMIT > 7 ||
      DEFAULT_MASTER < 0 || DEFAULT_MASTER > 3) begin : g_bad_param
    $error("lottery_arbiter: parameter out of range");
  end

  state_t     state_q, state_d;
  logic [3:0] hgrant_q, hgrant_d;
  logic [1:0] hmaster_q, hmaster_d;
  logic       hmastlock_q, hmastlock_d;
  logic [3:0] hold_q, hold_d;

  logic [3:0] tk [4];
  logic [1:0] owner_idx;
  logic       expiry;
  logic       arb_event;
  logic [3:0] cand;
  logic       any_req;
  logic       found;
  logic [1:0] win_idx;
  logic [3:0] win_tk;

`ifdef LOTTERY_STARVE_GUARD_EN
  localparam logic [2:0] STARVE_TH = 3'(STARVE_LIMIT);
  logic [2:0] starve_q [4];
  logic [2:0] starve_d [4];
`endif

  // Collect the tickets into an indexable array.
  always_comb begin
    tk[0] = t0;
    tk[1] = t1;
    tk[2] = t2;
    tk[3] = t3;
  end

  // Decode the one-hot grant into the owner index.
  always_comb begin
    owner_idx = 2'd0;
    case (hgrant_q)
      4'b0010: owner_idx = 2'd1;
      4'b0100: owner_idx = 2'd2;
      4'b1000: owner_idx = 2'd3;
      default: owner_idx = 2'd0;
    endcase
  end

  // Decide whether this edge is an arbitration event, and whether it is a hold expiry.
  always_comb begin
    expiry    = 1'b0;
    arb_event = 1'b0;
    case (state_q)
      ST_IDLE:   arb_event = 1'b1;
      ST_OWNED: begin
        expiry    = hbusreq[owner_idx] && (hold_q == HOLD_LAST);
        arb_event = !hbusreq[owner_idx] || (hold_q == HOLD_LAST);
      end
      ST_LOCKED: arb_event = !hlock[owner_idx];
      default:   arb_event = 1'b1;
    endcase
  end

  // Pick the winner: a starved requester first when enabled, else largest ticket, lowest index on ties.
  always_comb begin
    cand = hbusreq;
    if (expiry && |(hbusreq & ~hgrant_q)) cand = hbusreq & ~hgrant_q;
    any_req = |cand;
    win_idx = DEF_IDX;
    win_tk  = '0;
    found   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (cand[i] && (!found || tk[i] > win_tk)) begin
        found   = 1'b1;
        win_idx = 2'(i);
        win_tk  = tk[i];
      end
    end
`ifdef LOTTERY_STARVE_GUARD_EN
    // Walk downwards so the lowest starved index is the one that sticks.
    for (int i = 3; i >= 0; i--) begin
      if (cand[i] && starve_q[i] >= STARVE_TH) win_idx = 2'(i);
    end
`endif
  end

  // Next state and hold counter.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    if (arb_event) begin
      hold_d = '0;
      if (!any_req)              state_d = ST_IDLE;
      else if (hlock[win_idx])   state_d = ST_LOCKED;
      else                       state_d = ST_OWNED;
    end else if (state_q == ST_OWNED) begin
      hold_d = hold_q + 4'd1;
    end
  end

  // Registered outputs; the address-phase owner follows the grant by one cycle.
  always_comb begin
    hgrant_d = hgrant_q;
    if (arb_event) hgrant_d = any_req ? (4'b0001 << win_idx) : DEF_GRANT;
    hmaster_d   = owner_idx;
    hmastlock_d = hlock[owner_idx] & hbusreq[owner_idx];
  end

  // State register; everything holds while hready is low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      hgrant_q    <= DEF_GRANT;
      hmaster_q   <= DEF_IDX;
      hmastlock_q <= 1'b0;
      hold_q      <= '0;
    end else if (hready) begin
      state_q     <= state_d;
      hgrant_q    <= hgrant_d;
      hmaster_q   <= hmaster_d;
      hmastlock_q <= hmastlock_d;
      hold_q      <= hold_d;
    end
  end

`ifdef LOTTERY_STARVE_GUARD_EN
  // Loss counters: count lost events while requesting, clear on a win or a dropped request.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      starve_d[i] = starve_q[i];
      if (!hbusreq[i]) begin
        starve_d[i] = '0;
      end else if (arb_event) begin
        if (win_idx == 2'(i))            starve_d[i] = '0;
        else if (starve_q[i] != 3'd7)    starve_d[i] = starve_q[i] + 3'd1;
      end
    end
  end

  // Loss counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) starve_q[i] <= '0;
    end else if (hready) begin
      for (int i = 0; i < 4; i++) starve_q[i] <= starve_d[i];
    end
  end
`endif

  assign hgrant    = hgrant_q;
  assign hmaster   = hmaster_q;
  assign hmastlock = hmastlock_q;

endmodule
